// File: rtl/vred_pkg.sv
// Shared opcodes, SEW encodings, FSM states and lane helpers
// for the vector reduction sequencer.
package vred_pkg;

  localparam logic [2:0] OP_SUM  = 3'd0;
  localparam logic [2:0] OP_MINU = 3'd1;
  localparam logic [2:0] OP_MIN  = 3'd2;
  localparam logic [2:0] OP_MAXU = 3'd3;
  localparam logic [2:0] OP_MAX  = 3'd4;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FOLD,
    S_SCALAR,
    S_DONE
  } state_e;

  // Unknown opcodes behave as SUM.
  function automatic logic [2:0] op_norm(input logic [2:0] op);
    return (op inside {OP_MINU, OP_MIN, OP_MAXU, OP_MAX})
           ? op : OP_SUM;
  endfunction

  function automatic logic [6:0] sew_bits(input logic [1:0] sew);
    return 7'd8 << sew;
  endfunction

  // Identity element replicated across every lane of a 64-bit word.
  function automatic logic [63:0] vred_ident(input logic [2:0] op,
                                             input logic [1:0] sew);
    logic [63:0] smax;
    logic [63:0] r;
    unique case (sew)
      SEW_8:   smax = {8{8'h7F}};
      SEW_16:  smax = {4{16'h7FFF}};
      SEW_32:  smax = {2{32'h7FFF_FFFF}};
      default: smax = {1'b0, {63{1'b1}}};
    endcase
    unique case (op)
      OP_MINU: r = '1;
      OP_MIN:  r = smax;
      OP_MAX:  r = ~smax;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One element op on zero-extended w-bit operands. Left-aligning
  // both operands lets one compare serve signed and unsigned.
  function automatic logic [63:0] elem_op(input logic [2:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [6:0] w);
    logic [63:0] la;
    logic [63:0] lb;
    logic        lt_u;
    logic        lt_s;
    logic [63:0] r;
    la   = a << (7'd64 - w);
    lb   = b << (7'd64 - w);
    lt_u = la < lb;
    lt_s = $signed(la) < $signed(lb);
    unique case (op)
      OP_MINU: r = lt_u ? a : b;
      OP_MIN:  r = lt_s ? a : b;
      OP_MAXU: r = lt_u ? b : a;
      OP_MAX:  r = lt_s ? b : a;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vred_lane_combiner.sv
// Combinational lane-wise SUM/MIN/MAX of two words at a given SEW.
// Shared by the accumulate, fold and scalar steps.
module vred_lane_combiner
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            sew,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH-1:0] r8;
  logic [DATA_WIDTH-1:0] r16;
  logic [DATA_WIDTH-1:0] r32;
  logic [DATA_WIDTH-1:0] r64;

  // 8-bit lanes
  always_comb begin
    r8 = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      r8[i*8+:8] = 8'(elem_op(op, 64'(a[i*8+:8]),
                              64'(b[i*8+:8]), 7'd8));
  end

  // 16-bit lanes
  always_comb begin
    r16 = '0;
    for (int i = 0; i < DATA_WIDTH / 16; i++)
      r16[i*16+:16] = 16'(elem_op(op, 64'(a[i*16+:16]),
                                  64'(b[i*16+:16]), 7'd16));
  end

  // 32-bit lanes
  always_comb begin
    r32 = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++)
      r32[i*32+:32] = 32'(elem_op(op, 64'(a[i*32+:32]),
                                  64'(b[i*32+:32]), 7'd32));
  end

  if (DATA_WIDTH == 64) begin : g_w64
    assign r64 = elem_op(op, 64'(a), 64'(b), 7'd64);
  end else begin : g_w32
    assign r64 = r32;
  end

  // Pick the result for the active element width
  always_comb begin
    unique case (sew)
      SEW_8:   y = r8;
      SEW_16:  y = r16;
      SEW_32:  y = r32;
      default: y = r64;
    endcase
  end

endmodule

// File: rtl/vred_fold_seq.sv
// Reduction sequencer: accumulate beats, fold halves, add vs1[0].
// Optional masking is built when VRED_MASK_EN is defined.
module vred_fold_seq
  import vred_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic [DATA_WIDTH-1:0]   scalar_in,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OPSEL_WIDTH-1:0]  opSel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data
);

  localparam int         NB    = DATA_WIDTH / 8;
  localparam logic [6:0] DW7   = 7'(DATA_WIDTH);
  localparam logic [6:0] HALF0 = 7'(DATA_WIDTH / 2);

  state_e                state_q, state_d;
  logic [1:0]            sew_q, sew_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] scalar_q, scalar_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [6:0]            half_q, half_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic                  accept;
  logic                  load;
  logic                  step;
  logic [1:0]            c_sew;
  logic [2:0]            c_op;
  logic [6:0]            c_ew;
  logic [6:0]            ew_q;
  logic [DATA_WIDTH-1:0] lane0m;
  logic [DATA_WIDTH-1:0] beat_m;
  logic [DATA_WIDTH-1:0] cmb_b;
  logic [DATA_WIDTH-1:0] cmb_y;

  assign accept = in_valid & in_ready_q;
  assign load   = accept & in_first;
  assign step   = accept & (state_q == S_ACCUM);
  assign c_sew  = load ? 2'(sew) : sew_q;
  assign c_op   = load ? op_norm(3'(opSel)) : op_q;
  assign c_ew   = sew_bits(c_sew);
  assign ew_q   = sew_bits(sew_q);
  assign lane0m = {DATA_WIDTH{1'b1}} >> (DW7 - ew_q);

`ifdef VRED_MASK_EN
  localparam int MW = (NB > 1) ? $clog2(NB) : 1;
  logic [63:0]           id64;
  logic [DATA_WIDTH-1:0] ident;
  logic [MW-1:0]         idx;

  assign id64  = vred_ident(c_op, c_sew);
  assign ident = id64[DATA_WIDTH-1:0];

  // Inactive elements take the identity, keyed by their lowest byte
  always_comb begin
    beat_m = in_data;
    idx    = '0;
    for (int j = 0; j < NB; j++) begin
      idx = MW'(j) & ~MW'((c_ew >> 3) - 7'd1);
      if (!in_mask[idx])
        beat_m[j*8+:8] = ident[j*8+:8];
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^in_mask;
  assign beat_m      = in_data;
`endif

  vred_lane_combiner #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_comb (
    .a  (acc_q),
    .b  (cmb_b),
    .sew(c_sew),
    .op (c_op),
    .y  (cmb_y)
  );

  // Next-state, operand mux and datapath updates
  always_comb begin
    state_d    = state_q;
    sew_d      = sew_q;
    op_d       = op_q;
    scalar_d   = scalar_q;
    acc_d      = acc_q;
    half_d     = half_q;
    out_data_d = out_data_q;
    cmb_b      = beat_m;
    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (load) begin
          sew_d    = 2'(sew);
          op_d     = op_norm(3'(opSel));
          scalar_d = scalar_in;
          acc_d    = beat_m;
          half_d   = HALF0;
        end else if (step) begin
          acc_d = cmb_y;
        end
        if (load || step) begin
          if (in_last)
            state_d = (c_ew < DW7) ? S_FOLD : S_SCALAR;
          else
            state_d = S_ACCUM;
        end
      end
      S_FOLD: begin
        cmb_b = acc_q >> half_q;
        acc_d = cmb_y;
        if (half_q <= ew_q)
          state_d = S_SCALAR;
        else
          half_d = half_q >> 1;
      end
      S_SCALAR: begin
        cmb_b      = scalar_q;
        out_data_d = cmb_y & lane0m;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_ACCUM);
    out_valid_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sew_q       <= SEW_8;
      op_q        <= OP_SUM;
      scalar_q    <= '0;
      acc_q       <= '0;
      half_q      <= HALF0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sew_q       <= sew_d;
      op_q        <= op_d;
      scalar_q    <= scalar_d;
      acc_q       <= acc_d;
      half_q      <= half_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_vred_fold_seq.sv
// Scoreboard bench for vred_fold_seq at DATA_WIDTH=32.
// Expected results are hand-computed directed vectors.
module tb_vred_fold_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_first;
  logic        in_last;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic [31:0] scalar_in;
  logic [1:0]  sew;
  logic [2:0]  opSel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  vred_fold_seq #(
    .DATA_WIDTH (32),
    .SEW_WIDTH  (2),
    .OPSEL_WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_last  (in_last),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .scalar_in(scalar_in),
    .sew      (sew),
    .opSel    (opSel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  // Monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected none",
                 out_data);
      end else begin
        check(name_q.pop_front(), out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic f, input logic l,
                      input logic [31:0] d, input logic [3:0] m,
                      input logic [31:0] s, input logic [1:0] sw,
                      input logic [2:0] op);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_first  = f;
    in_last   = l;
    in_data   = d;
    in_mask   = m;
    scalar_in = s;
    sew       = sw;
    opSel     = op;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50)
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid rises
  task automatic wait_out(input string name, input int exp_edges);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    check(name, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_mask   = 4'hF;
    scalar_in = '0;
    sew       = 2'd0;
    opSel     = 3'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);

    // SUM sew8 single beat: 1+2+3+4+0x10
    expect_out("t1_sum8", 32'h0000_001A);
    send(1, 1, 32'h0403_0201, 4'hF, 32'h10, 2'd0, 3'd0);
    wait_out("t1_latency", 3);

    // MAX sew16 signed: lanes {0x8000,5} and {7,-1}
    expect_out("t2_max16", 32'h0000_0007);
    send(1, 0, 32'h8000_0005, 4'hF, 32'h3, 2'd1, 3'd4);
    send(0, 1, 32'h0007_FFFF, 4'hF, 32'h3, 2'd1, 3'd4);
    wait_out("t2_latency", 2);

    // MAXU sew16 unsigned
    expect_out("t2_maxu16", 32'h0000_FFFF);
    send(1, 0, 32'h8000_0005, 4'hF, 32'h3, 2'd1, 3'd3);
    send(0, 1, 32'h0007_FFFF, 4'hF, 32'h3, 2'd1, 3'd3);
    wait_out("t2u_latency", 2);

    // MINU sew32 with output backpressure
    expect_out("t3_minu32", 32'h0000_0003);
    send(1, 0, 32'd5, 4'hF, 32'd4, 2'd2, 3'd1);
    send(0, 0, 32'd3, 4'hF, 32'd4, 2'd2, 3'd1);
    out_ready = 1'b0;
    send(0, 1, 32'd9, 4'hF, 32'd4, 2'd2, 3'd1);
    wait_out("t3_latency", 1);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_data", out_data, 32'h3);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valid_drop", 32'(out_valid), 32'd0);
    check("t3_in_ready_back", 32'(in_ready), 32'd1);

    // SUM sew8 with byte 3 masked off
`ifdef VRED_MASK_EN
    expect_out("t4_mask_sum8", 32'h0000_0006);
`else
    expect_out("t4_mask_sum8", 32'h0000_0005);
`endif
    send(1, 1, 32'hFF01_0203, 4'b0111, 32'h0, 2'd0, 3'd0);
    wait_out("t4_latency", 3);

    // MIN sew8 signed: min of 7F,01,80,7F and 05
    expect_out("min8_signed", 32'h0000_0080);
    send(1, 1, 32'h7F80_017F, 4'hF, 32'h05, 2'd0, 3'd2);
    wait_out("min8_latency", 3);

    // Reset while folding: no output may appear
    send(1, 1, 32'h0403_0201, 4'hF, 32'h10, 2'd0, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("t5_still_idle", 32'(out_valid), 32'd0);
    expect_out("t5_sum8_wrap", 32'h0000_0000);
    send(1, 1, 32'h8080_8080, 4'hF, 32'h0, 2'd0, 3'd0);
    wait_out("t5_latency", 3);

    // Beat without in_first in IDLE is dropped; restart in ACCUM
    send(0, 1, 32'd100, 4'hF, 32'd0, 2'd2, 3'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_out", 32'(out_valid), 32'd0);
    expect_out("t6_restart", 32'h0000_0007);
    send(1, 0, 32'd1, 4'hF, 32'd0, 2'd2, 3'd0);
    send(0, 0, 32'd2, 4'hF, 32'd0, 2'd2, 3'd0);
    send(1, 1, 32'd7, 4'hF, 32'd0, 2'd2, 3'd0);
    wait_out("t6_latency", 1);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vred_fold_seq.md
Name: vred_fold_seq

Overview:
Reduction sequencer for vredsum/vredmin[u]/vredmax[u].
- Accepts a stream of vector-register beats (DATA_WIDTH bits, several SEW lanes per beat) and accumulates them lane-wise into an internal accumulator.
- Folds the accumulator down to a single element with log2 halving passes.
- Combines that element with the scalar operand vs1[0] and returns the SEW-wide result through a valid/ready output.
- Sits between the vector register read port and the writeback path of the vALU.

Parameters:
- DATA_WIDTH, 32, bits per input beat and per output word; legal values 32 or 64.
- SEW_WIDTH, 2, width of the sew field.
- OPSEL_WIDTH, 3, width of the opSel field.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_first  in  1  first beat of a reduction; sew, opSel and scalar_in are captured with it
- in_last  in  1  last beat of a reduction
- in_data  in  DATA_WIDTH  vector elements
- in_mask  in  DATA_WIDTH/8  byte enables; an element is active when the mask bit of its lowest byte is set
- scalar_in  in  DATA_WIDTH  vs1[0] in bits [SEW-1:0]
- sew  in  SEW_WIDTH  0=8b, 1=16b, 2=32b, 3=64b (3 is legal only when DATA_WIDTH=64)
- opSel  in  OPSEL_WIDTH  0=SUM, 1=MINU, 2=MIN, 3=MAXU, 4=MAX; all other values are treated as SUM
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_WIDTH  result in lane 0, upper bits zero

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, accumulator=0. A reset in any state aborts the reduction in progress with no output.
- States: IDLE, ACCUM, FOLD, SCALAR, DONE.
- IDLE: in_ready=1.
  - A beat accepted with in_first=1 latches sew, opSel and scalar_in, and loads acc with in_data, inactive lanes replaced by the op identity.
  - If that beat also has in_last=1, the next state is FOLD (or SCALAR when F=0). Otherwise the next state is ACCUM.
  - A beat accepted without in_first is discarded.
- ACCUM: in_ready=1. Each accepted beat does acc <= combine(acc, masked beat) lane-wise, one beat per cycle.
  - in_first=1 restarts: reload exactly as in IDLE.
  - in_last=1 moves to FOLD, or to SCALAR when F=0.
- FOLD: in_ready=0. F = log2(DATA_WIDTH/SEW) passes. Each pass does acc[W/2-1:0] <= combine(lower half, upper half) and halves the live width W; the upper bits are don't-care.
- SCALAR: in_ready=0. One cycle: res <= combine(acc lane0, scalar lane0). Next state DONE.
- DONE: out_valid=1 and out_data={zeros, res}, both held stable while out_ready=0. Transfer happens when out_ready=1; next state IDLE with out_valid=0.
- Latency: out_valid rises F+1 clock edges after the edge that accepted the last beat. Example: DATA_WIDTH=32, sew8 gives 3 edges; sew32 gives 1 edge.
- Arithmetic:
  - SUM wraps modulo 2^SEW.
  - MIN/MAX compare two's-complement; MINU/MAXU compare unsigned.
  - Identities: SUM 0; MINU all-ones; MIN 0x7F..F; MAXU 0; MAX 0x80..0.
- Back-to-back: in_ready returns to 1 in the cycle after the output transfer.

Optional Feature:
VRED_MASK_EN
- Defined: in_mask is honoured and inactive elements contribute the identity.
- Undefined: in_mask is ignored, all elements are active, and no masking logic is built.

Decomposition:
- Package vred_pkg holds:
  - opcode constants (OP_SUM..OP_MAX)
  - sew encodings
  - state enum
  - identity-value function of (op, sew)
- Sub-module vred_lane_combiner: combinational lane-wise SUM/MIN/MAX over DATA_WIDTH at the given sew. It is shared by the ACCUM, FOLD and SCALAR datapaths through an operand mux.

Test Plan:
All scenarios use DATA_WIDTH=32.
1. SUM sew8, single beat (first & last) in_data 0x04030201, scalar 0x10 -> out_data 0x0000001A, out_valid 3 edges after accept.
2. MAX sew16, beats 0x80000005 then 0x0007FFFF, scalar 0x0003 -> 0x00000007. Repeat with MAXU -> 0x0000FFFF.
3. MINU sew32, beats 5, 3, 9, scalar 4 -> 3. Hold out_ready=0 for 3 cycles -> out_data stable, in_ready=0, then a single transfer.
4. SUM sew8, data 0xFF010203, mask 0b0111, scalar 0 -> 0x06 with VRED_MASK_EN, 0x05 without (wrap of 0x105).
5. Reset during FOLD -> out_valid=0, in_ready=1 next cycle. A following SUM sew8 of 0x80808080 with scalar 0 -> 0x00.
6. ACCUM with beats 1 and 2, then a beat with in_first=1 and in_last=1 carrying 7, SUM sew32, scalar 0 -> 7 (restart discards the earlier beats).
